// File: rtl/regwb_ctrl.sv
// ---------------------------------------------------------------------------
// regwb_ctrl -- register-file writeback controller with issue scoreboard.
//
// Merges two result sources onto a single registered register-file write
// port. Load results (mem_*) always win and are never buffered; ALU results
// (alu_*) queue in a small in-order FIFO and drain whenever the port is free.
// If the FIFO is empty and no load is present, an accepted ALU result goes
// straight to the write port without being written into the FIFO.
//
// A 31-entry scoreboard tracks registers with a pending write. Issue of an
// instruction whose destination is already pending is refused (no WAW), and
// two combinational operand-check ports report pending writes to the issue
// stage. A register's busy bit drops at the same edge that raises we.
//
// Ports
//   clk                       rising-edge clock
//   rst                       asynchronous active-low reset
//   iss_valid/iss_rd          instruction issue with destination register
//   iss_ready                 issue accepted this cycle
//   alu_valid/alu_rd/alu_data ALU result; alu_ready = accepted this cycle
//   mem_valid/mem_rd/mem_data load result;  mem_ready = accepted this cycle
//   we/wa/wn                  registered register-file write port
//   chk_a1/chk_a2             operand registers to check
//   busy1/busy2               operand has a pending write
// ---------------------------------------------------------------------------
module regwb_ctrl #(
  parameter int FIFO_DEPTH = 4            // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wn,
  input  logic [4:0]  chk_a1,
  input  logic [4:0]  chk_a2,
  output logic        busy1,
  output logic        busy2
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Which source drives the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_FIFO,
    SRC_ALU
  } src_e;

  // Scoreboard; bit 0 is never set, so register 0 always reads as free.
  logic [31:0]      busy;
  logic [31:0]      busy_next;

  // ALU result FIFO.
  logic [4:0]       fifo_rd   [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;

  logic             alu_fire;
  logic             iss_fire;
  logic             push;
  logic             pop;

  src_e             sel_src;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;
  logic             sel_write;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // Readiness is based on the registered count only, so a pop in the same
  // cycle never lets a full FIFO accept another result.
  assign mem_ready = rst;
  assign alu_ready = rst && !fifo_full;
  assign iss_ready = rst && ((iss_rd == 5'd0) || !busy[iss_rd]);

  assign alu_fire  = alu_valid && alu_ready;
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);

  assign busy1 = (chk_a1 != 5'd0) && busy[chk_a1];
  assign busy2 = (chk_a2 != 5'd0) && busy[chk_a2];

  // Write-port select: load, then oldest buffered ALU result, then bypass.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    sel_src  = SRC_NONE;
    sel_rd   = 5'd0;
    sel_data = 32'd0;
    if (mem_valid && mem_ready) begin
      sel_src  = SRC_MEM;
      sel_rd   = mem_rd;
      sel_data = mem_data;
    end else if (!fifo_empty) begin
      sel_src  = SRC_FIFO;
      sel_rd   = fifo_rd[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (alu_fire) begin
      sel_src  = SRC_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign sel_write = (sel_src != SRC_NONE) && (sel_rd != 5'd0);

  // A bypassed ALU result is consumed directly and never enters the FIFO.
  assign push = alu_fire && (sel_src != SRC_ALU);
  assign pop  = (sel_src == SRC_FIFO);

  // Scoreboard update: clear the written register, then set the issued one,
  // so a forced same-register clear+set leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (sel_write) busy_next[sel_rd] = 1'b0;
    if (iss_fire)  busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  // FIFO pointers and occupancy. Pointer widths equal log2(depth), so the
  // natural overflow of the increment is the modulo-depth wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only read
  // behind a valid count, and the pointers/count reset makes it empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  // Registered write port. Address and data hold when nothing is written,
  // including results addressed to register 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we <= 1'b0;
      wa <= 5'd0;
      wn <= 32'd0;
    end else if (sel_write) begin
      we <= 1'b1;
      wa <= sel_rd;
      wn <= sel_data;
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regwb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regwb_ctrl -- self-checking bench for regwb_ctrl.
// Directed scenarios with fixed expectations, then a randomized run checked
// against a queue-based model of the writeback rules.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later
// (combinational) or 1 ns after the next rising edge (registered).
// ---------------------------------------------------------------------------
module tb_regwb_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wn;
  logic [4:0]  chk_a1;
  logic [4:0]  chk_a2;
  logic        busy1;
  logic        busy2;

  int n_tests = 0;
  int n_fail  = 0;

  regwb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .we        (we),
    .wa        (wa),
    .wn        (wn),
    .chk_a1    (chk_a1),
    .chk_a2    (chk_a2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd   = 5'd0;
    alu_valid = 1'b0; alu_rd   = 5'd0; alu_data = 32'd0;
    mem_valid = 1'b0; mem_rd   = 5'd0; mem_data = 32'd0;
    chk_a1    = 5'd0; chk_a2   = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    n_tests++;
    if ({we, wa, wn, iss_ready, alu_ready, mem_ready} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%0b wa=%0d wn=%0h ir=%0b ar=%0b mr=%0b, expected all 0",
               we, wa, wn, iss_ready, alu_ready, mem_ready);
    end
    tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({iss_ready, alu_ready, mem_ready, we} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_release: got ir=%0b ar=%0b mr=%0b we=%0b, expected 1 1 1 0",
               iss_ready, alu_ready, mem_ready, we);
    end
    tick();
  endtask

  // Issue rd=5, ALU writes it back; busy visible until the write edge.
  task automatic test_basic();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_issue_ready: got %0b expected 1", iss_ready);
    end
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11; chk_a1 = 5'd5;
    #1;
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_before: got %0b expected 1", busy1);
    end
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b1, 5'd5, 32'h11}) begin
      n_fail++; $display("FAIL basic_write: got we=%0b wa=%0d wn=%0h expected 1 5 11", we, wa, wn);
    end
    idle();
    chk_a1 = 5'd5;
    #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_after: got %0b expected 0", busy1);
    end
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b0, 5'd5, 32'h11}) begin
      n_fail++; $display("FAIL basic_hold: got we=%0b wa=%0d wn=%0h expected 0 5 11", we, wa, wn);
    end
  endtask

  // Load and ALU result in the same cycle: load first, ALU from the FIFO next.
  task automatic test_mem_priority();
    idle();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hB;
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b1, 5'd3, 32'hA}) begin
      n_fail++; $display("FAIL prio_mem: got we=%0b wa=%0d wn=%0h expected 1 3 a", we, wa, wn);
    end
    idle();
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b1, 5'd4, 32'hB}) begin
      n_fail++; $display("FAIL prio_alu: got we=%0b wa=%0d wn=%0h expected 1 4 b", we, wa, wn);
    end
    tick();
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle: got we=%0b expected 0", we);
    end
  endtask

  // Six load cycles, five ALU offers: the fifth is refused, four drain in order.
  task automatic test_fifo_full();
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 32'h100 + 32'(i);
      if (i < 5) begin
        alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h200 + 32'(i);
      end
      #1;
      if (i < 5) begin
        n_tests++;
        if (alu_ready !== (i < 4)) begin
          n_fail++; $display("FAIL full_ready_%0d: got %0b expected %0b", i, alu_ready, (i < 4));
        end
      end
      tick();
      n_tests++;
      if ({we, wa, wn} !== {1'b1, 5'(20 + i), 32'h100 + 32'(i)}) begin
        n_fail++; $display("FAIL full_mem_%0d: got we=%0b wa=%0d wn=%0h", i, we, wa, wn);
      end
    end
    idle();
    #1;
    n_tests++;
    if (alu_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_ready: got %0b expected 0", alu_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({we, wa, wn} !== {1'b1, 5'(10 + i), 32'h200 + 32'(i)}) begin
        n_fail++; $display("FAIL full_drain_%0d: got we=%0b wa=%0d wn=%0h expected 1 %0d %0h",
                           i, we, wa, wn, 10 + i, 32'h200 + i);
      end
    end
    tick();
    n_tests++;
    if (we !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: got we=%0b expected 0", we);
    end
  endtask

  // Second issue to rd=7 stalls until the rd=7 writeback edge.
  task automatic test_waw();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL waw_first: got %0b expected 1", iss_ready);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      end
      #1;
      n_tests++;
      if (iss_ready !== 1'b0) begin
        n_fail++; $display("FAIL waw_stall_%0d: got %0b expected 0", k, iss_ready);
      end
      tick();
    end
    n_tests++;
    if ({we, wa, wn} !== {1'b1, 5'd7, 32'h77}) begin
      n_fail++; $display("FAIL waw_write: got we=%0b wa=%0d wn=%0h expected 1 7 77", we, wa, wn);
    end
    alu_valid = 1'b0;
    #1;
    n_tests++;
    if (iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL waw_release: got %0b expected 1", iss_ready);
    end
    tick();
    idle();
    chk_a1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0;
    #1;
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL waw_reissued: got %0b expected 1", busy1);
    end
    tick();
    idle();
    chk_a1 = 5'd7;
    #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL waw_cleared: got %0b expected 0", busy1);
    end
  endtask

  // Result to r0 is consumed silently; the port keeps its last address/data.
  task automatic test_rd0();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    n_tests++;
    if ({alu_ready, busy1} !== 2'b10) begin
      n_fail++; $display("FAIL rd0_ready: got ar=%0b b1=%0b expected 1 0", alu_ready, busy1);
    end
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b0, 5'd7, 32'h0}) begin
      n_fail++; $display("FAIL rd0_nowrite: got we=%0b wa=%0d wn=%0h expected 0 7 0", we, wa, wn);
    end
    alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    n_tests++;
    if ({we, wa, wn} !== {1'b1, 5'd9, 32'h99}) begin
      n_fail++; $display("FAIL rd0_next: got we=%0b wa=%0d wn=%0h expected 1 9 99", we, wa, wn);
    end
    idle();
    tick();
  endtask

  // Reset with three buffered results and two busy registers.
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      idle();
      iss_valid = (i < 2); iss_rd = 5'(12 + i);
      mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'(2 + i); alu_data = 32'h2 + 32'(i);
      tick();
    end
    idle();
    chk_a1 = 5'd12; chk_a2 = 5'd13;
    #1;
    n_tests++;
    if ({we, busy1, busy2, alu_ready} !== 4'b1111) begin
      n_fail++; $display("FAIL rmid_pre: got we=%0b b1=%0b b2=%0b ar=%0b expected 1 1 1 1",
                         we, busy1, busy2, alu_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({we, wa, wn, iss_ready, alu_ready, mem_ready, busy1, busy2} !== 43'd0) begin
      n_fail++; $display("FAIL rmid_async: got we=%0b wa=%0d wn=%0h ir=%0b ar=%0b mr=%0b b1=%0b b2=%0b",
                         we, wa, wn, iss_ready, alu_ready, mem_ready, busy1, busy2);
    end
    tick(); tick();
    rst = 1'b1;
    iss_rd = 5'd12;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if ({we, iss_ready, alu_ready, busy1, busy2} !== 5'b01100) begin
        n_fail++; $display("FAIL rmid_after_%0d: got we=%0b ir=%0b ar=%0b b1=%0b b2=%0b expected 0 1 1 0 0",
                           i, we, iss_ready, alu_ready, busy1, busy2);
      end
      tick();
    end
  endtask

  // Randomized traffic against a model: pending results are a plain queue,
  // loads preempt it, an accepted ALU result joins its tail and the head
  // leaves whenever no load is present.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  task automatic test_random(input int ncyc);
    res_t        q[$];
    bit          mbusy[32];
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wn;
    logic        e_iss, e_alu, e_b1, e_b2;
    res_t        sel;
    bit          have_sel;

    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    m_we = 1'b0; m_wa = 5'd0; m_wn = 32'd0;

    for (int c = 0; c < ncyc; c++) begin
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = 5'($urandom_range(0, 7));
      alu_valid = $urandom_range(0, 2) != 0;
      alu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      mem_valid = $urandom_range(0, 2) == 0;
      mem_rd    = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      chk_a1    = 5'($urandom_range(0, 7));
      chk_a2    = 5'($urandom_range(0, 7));
      #1;
      e_iss = (iss_rd == 5'd0) || !mbusy[iss_rd];
      e_alu = q.size() < DEPTH;
      e_b1  = (chk_a1 != 5'd0) && mbusy[chk_a1];
      e_b2  = (chk_a2 != 5'd0) && mbusy[chk_a2];
      n_tests++;
      if ({iss_ready, alu_ready, mem_ready, busy1, busy2} !== {e_iss, e_alu, 1'b1, e_b1, e_b2}) begin
        n_fail++; $display("FAIL rnd_comb_%0d: got ir=%0b ar=%0b mr=%0b b1=%0b b2=%0b expected %0b %0b 1 %0b %0b",
                           c, iss_ready, alu_ready, mem_ready, busy1, busy2, e_iss, e_alu, e_b1, e_b2);
      end

      if (alu_valid && e_alu) q.push_back('{rd: alu_rd, data: alu_data});
      have_sel = 1'b1;
      if (mem_valid)         sel = '{rd: mem_rd, data: mem_data};
      else if (q.size() > 0) sel = q.pop_front();
      else                   have_sel = 1'b0;
      m_we = have_sel && (sel.rd != 5'd0);
      if (m_we) begin
        m_wa = sel.rd;
        m_wn = sel.data;
        mbusy[sel.rd] = 1'b0;
      end
      if (iss_valid && e_iss && iss_rd != 5'd0) mbusy[iss_rd] = 1'b1;

      tick();
      n_tests++;
      if ({we, wa, wn} !== {m_we, m_wa, m_wn}) begin
        n_fail++; $display("FAIL rnd_write_%0d: got we=%0b wa=%0d wn=%0h expected %0b %0d %0h",
                           c, we, wa, wn, m_we, m_wa, m_wn);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem_priority();
    test_fifo_full();
    test_waw();
    test_rd0();
    test_reset_mid();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regwb_ctrl.md
REGWB_CTRL -- requirements
Module: regwb_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, ALU result buffer entries (power of 2, >=2).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 iss_valid  in  1  issue stage presents an instruction with destination iss_rd.
REQ-006 iss_rd  in  5  destination register of issuing instruction.
REQ-007 iss_ready  out  1  issue accepted this cycle.
REQ-008 alu_valid / alu_rd / alu_data  in  1/5/32  ALU result.
REQ-009 alu_ready  out  1  ALU result accepted this cycle.
REQ-010 mem_valid / mem_rd / mem_data  in  1/5/32  load result.
REQ-011 mem_ready  out  1  load result accepted this cycle.
REQ-012 we / wa / wn  out  1/5/32  registered register-file write port.
REQ-013 chk_a1, chk_a2  in  5  operand registers to check.
REQ-014 busy1, busy2  out  1  operand has a pending write.

Function
REQ-015 Scoreboard: busy[31:1] bits; register 0 is never busy.
REQ-016 iss_ready = 1 when not in reset and (iss_rd == 0 or busy[iss_rd] == 0); no pending write-after-write allowed.
REQ-017 iss_valid && iss_ready && iss_rd != 0 sets busy[iss_rd] at the next edge.
REQ-018 ALU results enter a FIFO_DEPTH-entry FIFO; alu_ready = !full; same-cycle pop does not raise alu_ready when full.
REQ-019 mem_ready = 1 whenever not in reset; load results have absolute priority and are never buffered.
REQ-020 Each cycle, write-port select: mem result if mem_valid; else FIFO head if FIFO non-empty; else none.
REQ-021 FIFO bypass: when FIFO is empty and mem_valid = 0, an accepted ALU result is selected directly, and the FIFO is not written.
REQ-022 The selected result loads we/wa/wn at the next edge, giving 1-cycle latency. we = 1 only when selected rd != 0. Otherwise we = 0 and wa/wn hold their values.
REQ-023 When the selected rd != 0, busy[rd] clears at the same edge that asserts we.
REQ-024 Clear and set of the same register in one cycle is impossible by REQ-016. If it is forced, set SHALL win.
REQ-025 A result to a non-busy register is still written; the scoreboard is unchanged.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
REQ-027 FIFO order is strict; a result never overtakes an older ALU result.
REQ-028 busyN = (chk_aN != 0) && busy[chk_aN], combinational.
REQ-029 When we = 1, the register file forwards wn, so a consumer of wa sees the correct value in the cycle busy drops.

Reset
REQ-030 rst low SHALL immediately force the following:
- we = 0, wa = 0, wn = 0.
- busy[] = 0, FIFO empty, pointers = 0.
- iss_ready = 0, alu_ready = 0, mem_ready = 0.
REQ-031 Reset mid-operation discards buffered results and pending busy bits without emitting writes.
REQ-032 After rst rises, the first edge operates normally; alu_ready = 1 and mem_ready = 1 in that cycle.

Verification
REQ-033 Issue rd=5, then ALU result rd=5, data=0x11 -> next cycle: we=1, wa=5, wn=0x11, busy[5]=0; busy1=1 when checking 5 in the cycle before the write.
REQ-034 mem_valid (rd=3, 0xA) and alu_valid (rd=4, 0xB) in the same cycle -> cycle+1: write 3/0xA; cycle+2: write 4/0xB from the FIFO.
REQ-035 Hold mem_valid for 6 cycles while pushing 5 ALU results (depth 4) -> alu_ready=0 on the 5th result. After mem stops, 4 writes follow in push order.
REQ-036 Issue rd=7, then issue rd=7 again -> iss_ready=0 until the rd=7 writeback edge; iss_ready=1 the cycle after.
REQ-037 ALU result rd=0 -> we stays 0, no busy change, result consumed.
REQ-038 Assert rst with 3 buffered results and 2 busy bits -> all outputs 0 immediately; no writes after rst is released.
